ifetch_queue: RTL

- Instruction fetch front end that sits directly upstream of the mips core's decode stage.
- Generates sequential word fetch addresses and issues them to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions, with their PCs, in a small in-order FIFO and presents them to decode over valid/ready.
- Accepts a redirect (jump, branch or jr target) that flushes the queue and discards responses still in flight.

---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/ifetch_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : shared constants and types for the mips fetch front end
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [31:0] PC_INIT_DEFAULT = 32'h8002_0000;
  localparam logic [31:0] WORD_BYTES      = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo : in-order FIFO of fetched instructions with push, pop, flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  fetch_entry_t      r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_depth);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  always @(posedge clk) begin
    if (!reset && !i_flush) assert (!(i_push && o_full && !w_pop));
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue : sequential instruction fetch with credit-limited requests,
//                in-order response buffering and redirect/flush handling
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifetch_queue
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_INIT = PC_INIT_DEFAULT,
  parameter int          DEPTH   = 4,
  parameter int          MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        align_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam logic [31:0]   c_depth   = 32'(DEPTH);
  localparam logic [OW-1:0] c_max_out = OW'(MAX_OUT);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;
  logic          r_align_err;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wr_entry;
  logic          w_full;
  logic          w_empty;
  logic          w_grant;
  logic          w_rvalid;
  logic          w_keep;
  logic          w_pop;
  logic [OW-1:0] w_out_next;
  logic          w_credit_ok;

  // Credit counts both buffered and in-flight words so every response has a slot.
  assign w_credit_ok = ((32'(w_count) + 32'(r_outstanding)) < c_depth) &&
                       (r_outstanding < c_max_out) && !w_full;

  assign mem_req  = !reset && !redirect_valid && w_credit_ok;
  assign mem_addr = r_fetch_pc;

  assign w_grant    = mem_req && mem_gnt;
  assign w_rvalid   = mem_rvalid && !reset;
  assign w_keep     = w_rvalid && (r_discard == '0) && !redirect_valid;
  assign w_pop      = out_valid && out_ready;
  assign w_out_next = r_outstanding + OW'(w_grant) - OW'(w_rvalid);

  assign w_wr_entry.instr = mem_rdata;
  assign w_wr_entry.pc    = r_rsp_pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_keep),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !reset && !w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign align_err = !reset && r_align_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= PC_INIT;
      r_rsp_pc      <= PC_INIT;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_align_err   <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_align_err   <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old stream.
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_rsp_pc   <= {redirect_pc[31:2], 2'b00};
        r_discard  <= w_out_next;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + WORD_BYTES;
        if (w_rvalid) begin
          if (r_discard != '0) r_discard <= r_discard - 1'b1;
          else                 r_rsp_pc  <= r_rsp_pc + WORD_BYTES;
        end
      end
    end
  end

endmodule

`default_nettype wire
